// File: rtl/ac_panel_ctrl.sv
// ac_panel_ctrl: user-input front end of the air-conditioner controller.
// Five raw push-buttons are synchronised and debounced, and each produces a
// single-cycle press pulse. A small OFF/ON state machine turns those pulses
// into the on/off flag, requested mode, set temperature and recharge power
// that the mode/thermal stage consumes.
//
// state  | meaning
// -------+----------------------------------------------------------------
// ST_OFF | unit idle; charge presses top up power_out, power press turns on
//        | only if power_fb is non-zero
// ST_ON  | unit running; mode/up/down presses act, power press or
//        | power_fb==0 returns to ST_OFF and latches power_fb into power_out

module ac_panel_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter logic [8:0]  TEMP_MIN     = 9'd160,
  parameter logic [8:0]  TEMP_MAX     = 9'd300,
  parameter logic [8:0]  TEMP_STEP    = 9'd5,
  parameter logic [8:0]  TEMP_INIT    = 9'd250,
  parameter logic [9:0]  POWER_INIT   = 10'd100,
  parameter logic [9:0]  POWER_MAX    = 10'd999,
  parameter logic [9:0]  CHARGE_STEP  = 10'd50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_power,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_charge,
  input  logic [9:0] power_fb,
  output logic       on_off,
  output logic [1:0] mode_out,
  output logic [8:0] set_temp,
  output logic [9:0] power_out
);

  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned CNT_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  localparam int unsigned B_POWER  = 0;
  localparam int unsigned B_MODE   = 1;
  localparam int unsigned B_UP     = 2;
  localparam int unsigned B_DOWN   = 3;
  localparam int unsigned B_CHARGE = 4;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } state_t;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] sync_a;
  logic [NUM_BTN-1:0] sync_b;
  logic [NUM_BTN-1:0] btn_acc;
  logic [NUM_BTN-1:0] btn_acc_d;
  logic [NUM_BTN-1:0] press;
  logic [CNT_W-1:0]   db_cnt [NUM_BTN];

  logic p_power;
  logic p_mode;
  logic p_up;
  logic p_down;
  logic p_charge;
  logic p_updn_any;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  mode_nxt;
  logic [8:0]  temp_nxt;
  logic [9:0]  power_nxt;
  logic [10:0] charge_sum;

  assign btn_raw = {btn_charge, btn_down, btn_up, btn_mode, btn_power};

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  // Debounce: the counter only runs while the synchronised level disagrees
  // with the accepted level, so any bounce back restarts the stability window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_acc <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync_b[i] == btn_acc[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          btn_acc[i] <= sync_b[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rising edge of an accepted level becomes a registered one-cycle press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_acc_d <= '0;
      press     <= '0;
    end else begin
      btn_acc_d <= btn_acc;
      press     <= btn_acc & ~btn_acc_d;
    end
  end

  assign p_power    = press[B_POWER];
  assign p_mode     = press[B_MODE];
  assign p_up       = press[B_UP];
  assign p_down     = press[B_DOWN];
  assign p_charge   = press[B_CHARGE];
  assign p_updn_any = p_up | p_down;

  // 11-bit sum so the saturation compare sees the carry.
  assign charge_sum = {1'b0, power_out} + {1'b0, CHARGE_STEP};

  // Next-state and output-register logic; a higher-priority press in the
  // same cycle swallows every lower-priority one.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_out;
    temp_nxt  = set_temp;
    power_nxt = power_out;
    case (state)
      ST_OFF: begin
        if (p_power) begin
          if (power_fb != '0) begin
            state_nxt = ST_ON;
          end
        end else if (p_charge && !p_mode && !p_updn_any) begin
          if (charge_sum > {1'b0, POWER_MAX}) begin
            power_nxt = POWER_MAX;
          end else begin
            power_nxt = charge_sum[9:0];
          end
        end
      end
      ST_ON: begin
        if (p_power || (power_fb == '0)) begin
          // Hand the live remaining power back so the downstream load does
          // not jump when the mode stage reloads it.
          state_nxt = ST_OFF;
          power_nxt = power_fb;
          mode_nxt  = 2'b00;
        end else if (p_mode) begin
          case (mode_out)
            2'b00:   mode_nxt = 2'b01;
            2'b01:   mode_nxt = 2'b10;
            default: mode_nxt = 2'b00;
          endcase
        end else if (p_up && !p_down) begin
          if (set_temp >= (TEMP_MAX - TEMP_STEP)) begin
            temp_nxt = TEMP_MAX;
          end else begin
            temp_nxt = set_temp + TEMP_STEP;
          end
        end else if (p_down && !p_up) begin
          if (set_temp <= (TEMP_MIN + TEMP_STEP)) begin
            temp_nxt = TEMP_MIN;
          end else begin
            temp_nxt = set_temp - TEMP_STEP;
          end
        end
      end
      default: begin
        state_nxt = ST_OFF;
      end
    endcase
  end

  // State and user-setting registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_OFF;
      mode_out  <= 2'b00;
      set_temp  <= TEMP_INIT;
      power_out <= POWER_INIT;
    end else begin
      state     <= state_nxt;
      mode_out  <= mode_nxt;
      set_temp  <= temp_nxt;
      power_out <= power_nxt;
    end
  end

  assign on_off = (state == ST_ON);

endmodule
